// File: rtl/difftest_step_batcher.sv
`default_nettype none
// ============================================================================
// Module   : difftest_step_batcher
// Purpose  : Batches per-cycle difftest commit-step counts onto a valid/ready
//            port and throttles the core before the pending count saturates.
//            Optional statistics counters: DIFFTEST_BATCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module difftest_step_batcher #(
    parameter int STEP_WIDTH      = 8,
    parameter int ACC_WIDTH       = 16,
    parameter int BATCH_THRESHOLD = 64,
    parameter int FLUSH_TIMEOUT   = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] in_step,
    input  logic                  flush_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_step,
    output logic                  stall,
    output logic                  overflow,
    output logic [63:0]           stat_steps,
    output logic [31:0]           stat_batches
);

    localparam int                 c_TIMER_WIDTH = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [0:0]         c_S_ACCUM     = 1'b0;
    localparam logic [0:0]         c_S_ISSUE     = 1'b1;
    localparam logic [ACC_WIDTH:0] c_THRESHOLD   = (ACC_WIDTH+1)'(BATCH_THRESHOLD);
    localparam logic [c_TIMER_WIDTH-1:0] c_TIMEOUT = c_TIMER_WIDTH'(FLUSH_TIMEOUT);
    localparam logic [ACC_WIDTH:0] c_FULL        = {1'b1, {ACC_WIDTH{1'b0}}};
    localparam logic [ACC_WIDTH:0] c_MARGIN      = {{ACC_WIDTH{1'b0}}, 1'b1} << (STEP_WIDTH + 1);
    // Two max-size steps of headroom cover the commits already in flight when stall rises.
    localparam logic [ACC_WIDTH:0] c_STALL_LEVEL = c_FULL - c_MARGIN;

    logic [0:0]               r_state;
    logic [0:0]               w_state_next;
    logic [ACC_WIDTH-1:0]     r_pend;
    logic [ACC_WIDTH-1:0]     r_hold;
    logic [c_TIMER_WIDTH-1:0] r_timer;
    logic                     r_overflow;
    logic [ACC_WIDTH:0]       w_sum;
    logic [ACC_WIDTH-1:0]     w_sum_sat;
    logic                     w_issue;
    logic                     w_take;
    logic                     w_timer_active;

    assign w_sum     = {1'b0, r_pend} + {{(ACC_WIDTH + 1 - STEP_WIDTH){1'b0}}, in_step};
    assign w_sum_sat = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
    assign w_issue   = (w_sum != '0) &&
                       ((w_sum >= c_THRESHOLD) || (r_timer >= c_TIMEOUT) || flush_req);
    // While a batch is presented, a new one can only be cut on the handshake cycle.
    assign w_take    = (r_state == c_S_ACCUM) ? w_issue : (out_ready && w_issue);
    assign w_timer_active = (r_pend != '0) || (in_step != '0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_S_ACCUM;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_ACCUM: if (w_issue) w_state_next = c_S_ISSUE;
            c_S_ISSUE: if (out_ready) w_state_next = w_issue ? c_S_ISSUE : c_S_ACCUM;
            default:   w_state_next = c_S_ACCUM;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (r_state == c_S_ISSUE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend     <= '0;
            r_hold     <= '0;
            r_timer    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_sum[ACC_WIDTH]) r_overflow <= 1'b1;
            if (w_take) begin
                r_hold  <= w_sum_sat;
                r_pend  <= '0;
                r_timer <= '0;
            end else begin
                r_pend <= w_sum_sat;
                if (!w_timer_active)          r_timer <= '0;
                else if (r_timer < c_TIMEOUT) r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign out_step = r_hold;
    assign overflow = r_overflow;
    assign stall    = ({1'b0, r_pend} >= c_STALL_LEVEL);

`ifdef DIFFTEST_BATCH_STATS_EN
    logic [63:0] r_stat_steps;
    logic [31:0] r_stat_batches;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_steps   <= '0;
            r_stat_batches <= '0;
        end else if (out_valid && out_ready) begin
            r_stat_steps   <= r_stat_steps + {{(64 - ACC_WIDTH){1'b0}}, r_hold};
            r_stat_batches <= r_stat_batches + 32'd1;
        end
    end

    assign stat_steps   = r_stat_steps;
    assign stat_batches = r_stat_batches;
`else
    assign stat_steps   = 64'd0;
    assign stat_batches = 32'd0;
`endif

endmodule
`default_nettype wire
